// File: rtl/mppt_pkg.sv
// Shared types and constants for the MPPT open-loop chain.
package mppt_pkg;

  localparam int DATA_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Bit positions inside the en[3:0] strobe bus
  localparam int EN_SAMPLE = 0;
  localparam int EN_LOAD   = 1;
  localparam int EN_START  = 2;
  localparam int EN_STOP   = 3;

endpackage

// File: rtl/pwm_dead_time.sv
// Complementary gate drive with delayed rising edges; falling edges pass straight through.
// Used by port_out_pwm only when PORT_OUT_DEADTIME_EN is defined.
module pwm_dead_time #(
  parameter int DEADTIME = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out_p,
  output logic out_n
);
  import mppt_pkg::*;

  logic [DEADTIME-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = (hist_q << 1) | DEADTIME'(in);
  end

  // History resets to all ones so neither side drives right out of reset.
  always_ff @(posedge clk) begin
    if (rst) hist_q <= '1;
    else     hist_q <= hist_d;
  end

  assign out_p = in & (&hist_q);
  assign out_n = ~in & ~(|hist_q);

endmodule

// File: rtl/port_out_pwm.sv
// Output port of the MPPT chain: clamped duty register and fixed-period PWM with a mid-on-time sample strobe.
// Define PORT_OUT_DEADTIME_EN to get the complementary pwm_n drive with dead-time insertion.
module port_out_pwm #(
  parameter int DATA_W   = mppt_pkg::DATA_W,
  parameter int PERIOD   = 64,
  parameter int DUTY_MIN = 2,
  parameter int DUTY_MAX = 60,
  parameter int DEADTIME = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d_i,
  input  logic [3:0]        en,
  output logic [DATA_W-1:0] D,
  output logic              pwm,
  output logic              pwm_n,
  output logic              period_end,
  output logic              sample_req,
  output logic              busy
);
  import mppt_pkg::*;

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] d_q, d_d, duty_act_q, duty_act_d;
  logic              pwm_raw_q, pwm_raw_d;
  logic              period_end_q, period_end_d;
  logic              sample_req_q, sample_req_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] d_clamped, cnt_ext;
  logic              active, at_last;

  assign active  = (state_q != IDLE);
  assign at_last = (cnt_q == CNT_LAST);
  assign cnt_ext = DATA_W'(cnt_q);

  always_comb begin
    d_clamped = d_i;
    if (d_i < DATA_W'(DUTY_MIN))      d_clamped = DATA_W'(DUTY_MIN);
    else if (d_i > DATA_W'(DUTY_MAX)) d_clamped = DATA_W'(DUTY_MAX);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    duty_act_d = duty_act_q;
    d_d        = en[EN_LOAD] ? d_clamped : d_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // stop wins over a simultaneous start
        if (en[EN_START] && !en[EN_STOP]) begin
          state_d    = RUN;
          duty_act_d = d_q;
        end
      end
      RUN:     if (en[EN_STOP]) state_d = STOP;
      STOP:    if (at_last)     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Duty is only ever swapped at the period boundary.
    if (active) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
      if (at_last) duty_act_d = d_q;
    end

    pwm_raw_d    = active && (cnt_ext < duty_act_q);
    period_end_d = active && at_last;
    sample_req_d = active && (cnt_ext == (duty_act_q >> 1));
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      d_q          <= '0;
      duty_act_q   <= '0;
      pwm_raw_q    <= 1'b0;
      period_end_q <= 1'b0;
      sample_req_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_q          <= d_d;
      duty_act_q   <= duty_act_d;
      pwm_raw_q    <= pwm_raw_d;
      period_end_q <= period_end_d;
      sample_req_q <= sample_req_d;
      busy_q       <= busy_d;
    end
  end

  assign D          = d_q;
  assign period_end = period_end_q;
  assign sample_req = sample_req_q;
  assign busy       = busy_q;

`ifdef PORT_OUT_DEADTIME_EN
  logic unused_en;
  assign unused_en = en[EN_SAMPLE];

  pwm_dead_time #(
    .DEADTIME (DEADTIME)
  ) u_dead_time (
    .clk   (clk),
    .rst   (rst),
    .in    (pwm_raw_q),
    .out_p (pwm),
    .out_n (pwm_n)
  );
`else
  // en[0] belongs to the input side; DEADTIME has no role without the complementary drive.
  logic unused_cfg;
  assign unused_cfg = ^{en[EN_SAMPLE], 32'(DEADTIME)};

  assign pwm   = pwm_raw_q;
  assign pwm_n = 1'b0;
`endif

endmodule

// File: tb/tb_port_out_pwm.sv
// Scoreboard bench for port_out_pwm: stimulus pushes expected per-period duty, monitor checks each period_end.
module tb_port_out_pwm;

`ifdef PORT_OUT_DEADTIME_EN
  localparam int DT_ADJ = 2;
`else
  localparam int DT_ADJ = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] d_i = '0;
  logic [3:0] en  = '0;
  logic [5:0] D;
  logic       pwm, pwm_n, period_end, sample_req, busy;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  port_out_pwm dut (
    .clk        (clk),
    .rst        (rst),
    .d_i        (d_i),
    .en         (en),
    .D          (D),
    .pwm        (pwm),
    .pwm_n      (pwm_n),
    .period_end (period_end),
    .sample_req (sample_req),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] e, input logic [5:0] d);
    en = e; d_i = d;
    @(posedge clk); #1;
    en = '0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: per-period window measured between period_end pulses
  int hi, len, samp_cnt, samp_pos, e_duty, e_samp;
  bit have_prev, ovl;

  always @(negedge clk) begin
    if (rst) begin
      hi = 0; len = 0; samp_cnt = 0; samp_pos = -1; have_prev = 0; ovl = 0;
    end else begin
`ifdef PORT_OUT_DEADTIME_EN
      if (pwm && pwm_n) ovl = 1;
`else
      if (pwm_n) ovl = 1;
`endif
      if (sample_req) begin samp_cnt++; samp_pos = hi; end
      if (pwm) hi++;
      len++;
      if (period_end) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_period_end: got period_end=1 expected none queued");
        end else begin
          e_duty = exp_q.pop_front();
          e_samp = (e_duty >> 1) - DT_ADJ;
          if (e_samp < 0) e_samp = 0;
          chk("pwm_high_cycles", hi, e_duty - DT_ADJ);
          chk("sample_req_pos", samp_pos, e_samp);
          chk("sample_req_count", samp_cnt, 1);
          chk("drive_overlap", {31'd0, ovl}, 0);
          if (have_prev) chk("period_len", len, 64);
        end
        hi = 0; len = 0; samp_cnt = 0; samp_pos = -1; have_prev = 1; ovl = 0;
      end else if (!busy) begin
        have_prev = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset
    cycles(3);
    chk("rst_D", D, 0);
    chk("rst_pwm", pwm, 0);
    chk("rst_pwm_n", pwm_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_period_end", period_end, 0);
    chk("rst_sample_req", sample_req, 0);
    rst = 1'b0;
    cycles(2);
    chk("idle_busy", busy, 0);

    // 2. normal run at duty 16, three periods before touching anything
    pulse(4'b0010, 6'd16);
    chk("load16_D", D, 16);
    pulse(4'b0100, 6'd0);
    exp_q.push_back(16); exp_q.push_back(16); exp_q.push_back(16);
    chk("start_busy", busy, 1);

    // 4. mid-period load at cnt=10 of period 3
    cycles(128 + 10);
    pulse(4'b0010, 6'd40);
    chk("load40_D", D, 40);
    exp_q.push_back(40);

    // 3. clamp low at cnt=30 of period 4, clamp high at cnt=30 of period 5
    cycles(83);
    pulse(4'b0010, 6'd0);
    chk("clamp_lo_D", D, 2);
    exp_q.push_back(2);
    cycles(63);
    pulse(4'b0010, 6'd63);
    chk("clamp_hi_D", D, 60);
    exp_q.push_back(60);

    // 5. stop at cnt=20 of period 6; period completes, then IDLE
    cycles(53);
    pulse(4'b1000, 6'd0);
    chk("stop_busy", busy, 1);
    cycles(42);
    chk("stop_busy_last", busy, 1);
    cycles(1);
    chk("stop_busy_drop", busy, 0);
    chk("stop_pwm_off", pwm, 0);
    cycles(3);
    chk("stop_pwm_idle", pwm, 0);
    chk("stop_queue_drained", exp_q.size(), 0);

    // start and stop together in IDLE: stays idle, no periods
    pulse(4'b1100, 6'd0);
    chk("startstop_busy", busy, 0);
    cycles(70);
    chk("startstop_busy_later", busy, 0);
    chk("startstop_pwm", pwm, 0);

    // 6. reset mid-run at cnt=5 with pwm high
    pulse(4'b0100, 6'd0);
    cycles(5);
    chk("midrun_pwm_high", pwm, 1);
    chk("midrun_busy", busy, 1);
    rst = 1'b1;
    cycles(1);
    chk("midrst_pwm", pwm, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_D", D, 0);
    chk("midrst_period_end", period_end, 0);
    rst = 1'b0;
    cycles(3);
    chk("post_rst_pwm", pwm, 0);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
